// File: rtl/cla_pkg.sv
// Shared gpk encoding and elaboration helpers for the pipelined carry-lookahead adder.
// Build option CLA_OVF_EN (in the top) adds a registered signed-overflow output.
`ifndef CLA_PREFIX_LEVELS
`define CLA_PREFIX_LEVELS(w) (cla_pkg::clog2(w))
`endif

package cla_pkg;

   typedef enum logic [1:0] {
      GPK_KILL = 2'b00,
      GPK_PROP = 2'b01,
      GPK_GEN  = 2'b11
   } gpk_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   function automatic gpk_t gpk_of(input logic a, input logic b);
      gpk_t code;
      code = GPK_PROP;
      if (a == b) code = a ? GPK_GEN : GPK_KILL;
      return code;
   endfunction

   // Index (0-based) of the pipeline register placed after prefix level `level`, or -1.
   function automatic int stage_at_level(input int level, input int levels, input int stages);
      int r;
      r = -1;
      for (int j = 1; j < stages; j++) begin
         if ((j * levels) / stages == level) r = j - 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/gpk_combine.sv
// Kogge-Stone prefix cell: the upper group wins unless it only propagates.
module gpk_combine
   import cla_pkg::*;
(
   input  logic [1:0] hi,
   input  logic [1:0] lo,
   output logic [1:0] y
);

   assign y = (hi != GPK_PROP) ? hi : lo;

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined Kogge-Stone carry-lookahead adder with valid/ready at both ends.
// Build option CLA_OVF_EN adds the ovf port (signed overflow, registered with sum).
module cla_pipe_adder
   import cla_pkg::*;
#(
   parameter int WIDTH  = 64,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef CLA_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int LEVELS = `CLA_PREFIX_LEVELS(WIDTH);
   localparam int PAD    = 1 << LEVELS;

   typedef logic [PAD-1:0][1:0] gvec_t;

   gvec_t             gen_g;
   gvec_t             node_g [LEVELS+1];
   gvec_t             src_g  [LEVELS+1];
   logic [WIDTH-1:0]  node_x [LEVELS+1];
   logic [WIDTH-1:0]  src_x  [LEVELS+1];
   logic              node_c [LEVELS+1];
   logic              src_c  [LEVELS+1];

   logic [STAGES-1:0] valid;
   logic [STAGES-1:0] en;
   logic [STAGES-1:0] up_valid;
   logic              stall;
   logic              fire;
   logic [WIDTH:0]    carry;

   // Handshake: a transfer happens on a rising edge where valid && ready; ready never
   // looks at the same side's valid, and a presented result holds until it is taken.
   assign out_valid = valid[STAGES-1];
   assign stall     = valid[STAGES-1] && !out_ready;
   assign in_ready  = !stall;
   assign fire      = in_valid && in_ready;

   // A stage may load when it is empty or its successor is loading, so bubbles collapse.
   always_comb begin
      en       = '0;
      up_valid = '0;
      en[STAGES-1] = !valid[STAGES-1] || out_ready;
      for (int k = STAGES - 2; k >= 0; k--) en[k] = !valid[k] || en[k+1];
      up_valid[0] = fire;
      for (int k = 1; k < STAGES; k++) up_valid[k] = valid[k-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid <= '0;
      else        valid <= (en & up_valid) | (~en & valid);
   end

   always_comb begin
      gen_g = '0;
      for (int i = 0; i < WIDTH; i++) gen_g[i] = gpk_of(a[i], b[i]);
      // cin is the bit -1 code; folding it into bit 0 keeps the tree at clog2(WIDTH) levels
      if (gen_g[0] == GPK_PROP) gen_g[0] = cin ? GPK_GEN : GPK_KILL;
   end

   assign node_g[0] = gen_g;
   assign node_x[0] = a ^ b;
   assign node_c[0] = cin;

   for (genvar m = 0; m < LEVELS; m++) begin : g_lvl
      localparam int SI = stage_at_level(m, LEVELS, STAGES);

      if (SI >= 0) begin : g_reg
         gvec_t            g_q;
         logic [WIDTH-1:0] x_q;
         logic             c_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               g_q <= '0;
               x_q <= '0;
               c_q <= 1'b0;
            end else if (en[SI] && up_valid[SI]) begin
               g_q <= node_g[m];
               x_q <= node_x[m];
               c_q <= node_c[m];
            end
         end

         assign src_g[m] = g_q;
         assign src_x[m] = x_q;
         assign src_c[m] = c_q;
      end else begin : g_wire
         assign src_g[m] = node_g[m];
         assign src_x[m] = node_x[m];
         assign src_c[m] = node_c[m];
      end

      for (genvar i = 0; i < PAD; i++) begin : g_bit
         if (i >= (1 << m)) begin : g_cell
            gpk_combine u_combine (
               .hi (src_g[m][i]),
               .lo (src_g[m][i - (1 << m)]),
               .y  (node_g[m+1][i])
            );
         end else begin : g_pass
            assign node_g[m+1][i] = src_g[m][i];
         end
      end

      assign node_x[m+1] = src_x[m];
      assign node_c[m+1] = src_c[m];
   end

   assign src_g[LEVELS] = node_g[LEVELS];
   assign src_x[LEVELS] = node_x[LEVELS];
   assign src_c[LEVELS] = node_c[LEVELS];

   // Padding lanes sit above every real bit, so they can never reach cout.
   if (PAD > WIDTH) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^src_g[LEVELS][PAD-1:WIDTH];
   end

   always_comb begin
      carry    = '0;
      carry[0] = src_c[LEVELS];
      for (int i = 1; i <= WIDTH; i++) carry[i] = (src_g[LEVELS][i-1] == GPK_GEN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum  <= '0;
         cout <= 1'b0;
      end else if (en[STAGES-1] && up_valid[STAGES-1]) begin
         sum  <= src_x[LEVELS] ^ carry[WIDTH-1:0];
         cout <= carry[WIDTH];
      end
   end

`ifdef CLA_OVF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   ovf <= 1'b0;
      else if (en[STAGES-1] && up_valid[STAGES-1]) ovf <= carry[WIDTH-1] ^ carry[WIDTH];
   end
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed 64-bit cases plus random streams on 13-bit builds.
// Define CLA_OVF_EN here as in the RTL build to connect and check ovf.
module tb_cla_pipe_adder;

   localparam int W       = 64;
   localparam int S       = 2;
   localparam int GEN_OPS = 10000;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid;
   logic         in_ready;
   logic         out_valid;
   logic         out_ready;
   logic         cin;
   logic         cout;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] sum;
`ifdef CLA_OVF_EN
   logic         ovf;
`endif

   always #5 clk = ~clk;

   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   gen_done = 0;
   logic dir_done = 1'b0;
   logic lat_chk  = 1'b0;

   logic [W+1:0] exp_q[$];
   int           acc_q[$];
   logic [2*W:0] stim_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   cla_pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef CLA_OVF_EN
      , .ovf     (ovf)
`endif
   );

   task automatic check_eq(input string tag, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [W+1:0] model64(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c);
      logic [W:0] r;
      r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      return {(x[W-1] == y[W-1]) && (r[W-1] != x[W-1]), r};
   endfunction

   task automatic push_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      stim_q.push_back({c, x, y});
   endtask

   task automatic step(input logic ordy);
      logic [W+1:0] e;
      int           c0;
      @(negedge clk);
      out_ready = ordy;
      if (stim_q.size() > 0) begin
         in_valid       = 1'b1;
         {cin, a, b}    = stim_q[0];
      end else begin
         in_valid = 1'b0;
      end
      #1;
      if (out_valid && !out_ready) check_eq("in_ready_stall", 72'(in_ready), 0);
      else                         check_eq("in_ready_free", 72'(in_ready), 1);
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_out", 72'(out_valid), 0);
         end else begin
            e  = exp_q.pop_front();
            c0 = acc_q.pop_front();
            check_eq("sum_cout", 72'({cout, sum}), 72'(e[W:0]));
`ifdef CLA_OVF_EN
            check_eq("ovf", 72'(ovf), 72'(e[W+1]));
`endif
            if (lat_chk) check_eq("latency", 72'(cyc - c0), S);
         end
      end
      if (in_valid && in_ready) begin
         void'(stim_q.pop_front());
         exp_q.push_back(model64(a, b, cin));
         acc_q.push_back(cyc);
      end
   endtask

   task automatic drain(input int budget);
      for (int c = 0; c < budget && (stim_q.size() > 0 || exp_q.size() > 0); c++) step(1'b1);
      check_eq("drain_empty", 72'(stim_q.size() + exp_q.size()), 0);
   endtask

   initial begin
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check_eq("reset_out_valid", 72'(out_valid), 0);
      check_eq("reset_sum_cout", 72'({cout, sum}), 0);
      check_eq("reset_in_ready", 72'(in_ready), 1);
`ifdef CLA_OVF_EN
      check_eq("reset_ovf", 72'(ovf), 0);
`endif
      rst_n = 1'b1;

      lat_chk = 1'b1;
      push_op(64'h0101010101010101, 64'h0101010101010101, 1'b0);
      drain(50);
      push_op(64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000, 1'b1);
      push_op(64'h8000000000000000, 64'h8000000000000000, 1'b0);
      push_op(64'h7FFFFFFFFFFFFFFF, 64'h0000000000000001, 1'b0);
      push_op(64'hFFFFFFFFFFFFFFFF, 64'h0000000000000001, 1'b0);
      push_op(64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 1'b1);
      push_op(64'h0000000000000000, 64'h0000000000000000, 1'b0);
      drain(50);

      lat_chk = 1'b0;
      for (int i = 0; i < 8; i++)
         push_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      for (int c = 0; c < 8; c++) step(!(c >= 3 && c <= 7));
      drain(100);

      lat_chk = 1'b1;
      push_op(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b1);
      push_op(64'h00000000FFFFFFFF, 64'h0000000000000001, 1'b0);
      step(1'b1);
      step(1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_mid_out_valid", 72'(out_valid), 0);
      check_eq("rst_mid_sum_cout", 72'({cout, sum}), 0);
      #1 rst_n = 1'b1;
      exp_q.delete();
      acc_q.delete();
      stim_q.delete();
      push_op(64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 1'b1);
      drain(50);
      repeat (6) step(1'b1);
      dir_done = 1'b1;

      lat_chk = 1'b0;
      for (int i = 0; i < 400; i++)
         push_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      for (int c = 0; c < 4000 && (stim_q.size() > 0 || exp_q.size() > 0); c++)
         step($urandom_range(0, 3) != 0);
      check_eq("rand_drain", 72'(stim_q.size() + exp_q.size()), 0);

      for (int c = 0; c < 60000 && gen_done < 2; c++) @(posedge clk);
      check_eq("gen_finished", 72'(gen_done), 2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   for (genvar g = 0; g < 2; g++) begin : g_cfg
      localparam int GW = 13;
      localparam int GS = (g == 0) ? 1 : 5;

      logic          iv   = 1'b0;
      logic          ordy = 1'b0;
      logic          ci   = 1'b0;
      logic [GW-1:0] ga   = '0;
      logic [GW-1:0] gb   = '0;
      logic          ir;
      logic          ov;
      logic          co;
      logic [GW-1:0] gs;
`ifdef CLA_OVF_EN
      logic          go;
`endif
      logic [GW+1:0] q[$];
      int            cq[$];
      int            sent = 0;
      int            got  = 0;
      logic          hold = 1'b0;

      cla_pipe_adder #(.WIDTH(GW), .STAGES(GS)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (iv),
         .in_ready  (ir),
         .a         (ga),
         .b         (gb),
         .cin       (ci),
         .out_valid (ov),
         .out_ready (ordy),
         .sum       (gs),
         .cout      (co)
`ifdef CLA_OVF_EN
         , .ovf     (go)
`endif
      );

      initial begin
         logic [GW:0]   r;
         logic [GW+1:0] e;
         int            c0;
         wait (dir_done);
         for (int c = 0; c < 50000 && got < GEN_OPS; c++) begin
            @(negedge clk);
            ordy = (c < 2000) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (!hold) begin
               iv = (sent < GEN_OPS) && ($urandom_range(0, 3) != 0);
               ga = GW'($urandom);
               gb = GW'($urandom);
               ci = 1'($urandom);
            end
            #1;
            if (ov && !ordy) check_eq("gen_in_ready_stall", 72'(ir), 0);
            if (ov && ordy) begin
               if (q.size() == 0) begin
                  check_eq("gen_spurious", 72'(ov), 0);
               end else begin
                  e  = q.pop_front();
                  c0 = cq.pop_front();
                  got++;
                  check_eq("gen_sum_cout", 72'({co, gs}), 72'(e[GW:0]));
`ifdef CLA_OVF_EN
                  check_eq("gen_ovf", 72'(go), 72'(e[GW+1]));
`endif
                  if (c0 >= 0) check_eq("gen_latency", 72'(c - c0), GS);
               end
            end
            if (iv && ir) begin
               r = {1'b0, ga} + {1'b0, gb} + {{GW{1'b0}}, ci};
               e = {(ga[GW-1] == gb[GW-1]) && (r[GW-1] != ga[GW-1]), r};
               q.push_back(e);
               cq.push_back((c < 1990) ? c : -1);
               sent++;
               hold = 1'b0;
            end else begin
               hold = iv;
            end
         end
         check_eq("gen_all_received", 72'(got), GEN_OPS);
         gen_done++;
      end
   end

endmodule
